// File: rtl/demux1x2x16_router_pkg.sv
// Shared constants for the 1-to-2 registered demux router.
// Optional statistics counters are enabled by defining DEMUX_STATS_EN.
package demux1x2x16_router_pkg;

   localparam int DATA_WIDTH = 16;
   localparam int STATS_W    = 16;

   localparam logic CH0 = 1'b0;
   localparam logic CH1 = 1'b1;

endpackage

// File: rtl/demux1x2x16_router_if.sv
// Handshake bundle between the producer, the router and the two consumers.
// count0/count1 exist only when DEMUX_STATS_EN is defined.
interface demux1x2x16_router_if #(
   parameter int DATA_WIDTH = demux1x2x16_router_pkg::DATA_WIDTH
);
   import demux1x2x16_router_pkg::*;

   logic [DATA_WIDTH-1:0] demux_input;
   logic                  selector;
   logic                  in_valid;
   logic                  in_ready;

   logic [DATA_WIDTH-1:0] demux_output0;
   logic                  out_valid0;
   logic                  out_ready0;

   logic [DATA_WIDTH-1:0] demux_output1;
   logic                  out_valid1;
   logic                  out_ready1;

`ifdef DEMUX_STATS_EN
   logic [STATS_W-1:0]    count0;
   logic [STATS_W-1:0]    count1;

   modport slave (
      input  demux_input, selector, in_valid, out_ready0, out_ready1,
      output in_ready, demux_output0, out_valid0, demux_output1, out_valid1,
      output count0, count1
   );

   modport master (
      output demux_input, selector, in_valid, out_ready0, out_ready1,
      input  in_ready, demux_output0, out_valid0, demux_output1, out_valid1,
      input  count0, count1
   );
`else
   modport slave (
      input  demux_input, selector, in_valid, out_ready0, out_ready1,
      output in_ready, demux_output0, out_valid0, demux_output1, out_valid1
   );

   modport master (
      output demux_input, selector, in_valid, out_ready0, out_ready1,
      input  in_ready, demux_output0, out_valid0, demux_output1, out_valid1
   );
`endif

endinterface

// File: rtl/demux1x2x16_router_slot.sv
// One-entry output register with valid/ready; "free" means it can take a word
// this cycle, either because it is empty or because it is draining.
module demux_slot #(
   parameter int DATA_WIDTH = demux1x2x16_router_pkg::DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   output logic                  free
);

   assign free = !out_valid || out_ready;

   // A load wins over a drain so back-to-back words stream at full rate.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data  <= '0;
         out_valid <= 1'b0;
      end else if (load) begin
         out_data  <= load_data;
         out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/demux1x2x16_router.sv
// Registered 1-to-2 demultiplexer steering a valid/ready stream by selector.
// Define DEMUX_STATS_EN to add per-channel delivered-word counters.
module demux1x2x16_router #(
   parameter int DATA_WIDTH = demux1x2x16_router_pkg::DATA_WIDTH
) (
   input  logic                        clk,
   input  logic                        rst,
   demux1x2x16_router_if.slave         bus
);
   import demux1x2x16_router_pkg::*;

   logic free0;
   logic free1;
   logic accept;
   logic load0;
   logic load1;

   // Ready depends only on the selected slot, so a blocked word never lets a later one pass.
   assign bus.in_ready = (bus.selector == CH1) ? free1 : free0;
   assign accept       = bus.in_valid && bus.in_ready;
   assign load0        = accept && (bus.selector == CH0);
   assign load1        = accept && (bus.selector == CH1);

   demux_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot0 (
      .clk       (clk),
      .rst       (rst),
      .load      (load0),
      .load_data (bus.demux_input),
      .out_ready (bus.out_ready0),
      .out_data  (bus.demux_output0),
      .out_valid (bus.out_valid0),
      .free      (free0)
   );

   demux_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot1 (
      .clk       (clk),
      .rst       (rst),
      .load      (load1),
      .load_data (bus.demux_input),
      .out_ready (bus.out_ready1),
      .out_data  (bus.demux_output1),
      .out_valid (bus.out_valid1),
      .free      (free1)
   );

`ifdef DEMUX_STATS_EN
   logic [STATS_W-1:0] count0_q;
   logic [STATS_W-1:0] count1_q;

   // Counters wrap naturally at 2**STATS_W.
   always_ff @(posedge clk) begin
      if (rst) begin
         count0_q <= '0;
         count1_q <= '0;
      end else begin
         if (bus.out_valid0 && bus.out_ready0)
            count0_q <= count0_q + 1'b1;
         if (bus.out_valid1 && bus.out_ready1)
            count1_q <= count1_q + 1'b1;
      end
   end

   assign bus.count0 = count0_q;
   assign bus.count1 = count1_q;
`endif

endmodule

// File: tb/tb_demux1x2x16_router.sv
// Directed self-checking bench for demux1x2x16_router.
// Stats checks run only when DEMUX_STATS_EN is defined.
module tb_demux1x2x16_router;

   logic clk;
   logic rst;
   int   checkCount;
   int   errorCount;

   demux1x2x16_router_if #(.DATA_WIDTH(16)) bus ();

   demux1x2x16_router #(.DATA_WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [15:0] data, input logic sel);
      bus.in_valid    = valid;
      bus.demux_input = data;
      bus.selector    = sel;
   endtask

   // Advance one edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checkCount     = 0;
      errorCount     = 0;
      rst            = 1'b1;
      bus.out_ready0 = 1'b0;
      bus.out_ready1 = 1'b0;
      applyStimulus(1'b0, 16'h0000, 1'b0);

      // Reset then idle
      step();
      step();
      checkOutput("rst_valid0", bus.out_valid0, 1'b0);
      checkOutput("rst_valid1", bus.out_valid1, 1'b0);
      checkOutput("rst_data0", bus.demux_output0, 16'h0000);
      checkOutput("rst_data1", bus.demux_output1, 16'h0000);
      checkOutput("rst_ready_sel0", bus.in_ready, 1'b1);
      bus.selector = 1'b1;
      #1;
      checkOutput("rst_ready_sel1", bus.in_ready, 1'b1);

      // Steering
      rst            = 1'b0;
      bus.out_ready0 = 1'b1;
      bus.out_ready1 = 1'b1;
      applyStimulus(1'b1, 16'h0001, 1'b0);
      step();
      checkOutput("steer_valid0", bus.out_valid0, 1'b1);
      checkOutput("steer_data0", bus.demux_output0, 16'h0001);
      checkOutput("steer_valid1_idle", bus.out_valid1, 1'b0);
      applyStimulus(1'b1, 16'h0002, 1'b1);
      step();
      checkOutput("steer_valid1", bus.out_valid1, 1'b1);
      checkOutput("steer_data1", bus.demux_output1, 16'h0002);
      checkOutput("steer_drain0", bus.out_valid0, 1'b0);
      checkOutput("steer_keep0", bus.demux_output0, 16'h0001);
      applyStimulus(1'b0, 16'h0000, 1'b0);
      step();
      checkOutput("steer_drain1", bus.out_valid1, 1'b0);

      // Backpressure on channel 0
      bus.out_ready0 = 1'b0;
      applyStimulus(1'b1, 16'h00AA, 1'b0);
      step();
      checkOutput("bp_valid0", bus.out_valid0, 1'b1);
      checkOutput("bp_data0", bus.demux_output0, 16'h00AA);
      applyStimulus(1'b1, 16'h00BB, 1'b0);
      #1;
      checkOutput("bp_blocked", bus.in_ready, 1'b0);
      step();
      checkOutput("bp_still_blocked", bus.in_ready, 1'b0);
      checkOutput("bp_hold0", bus.demux_output0, 16'h00AA);
      bus.out_ready0 = 1'b1;
      #1;
      checkOutput("bp_ready_on_drain", bus.in_ready, 1'b1);
      step();
      checkOutput("bp_swap_valid0", bus.out_valid0, 1'b1);
      checkOutput("bp_swap_data0", bus.demux_output0, 16'h00BB);
      applyStimulus(1'b0, 16'h0000, 1'b0);
      step();
      checkOutput("bp_empty0", bus.out_valid0, 1'b0);

      // Independence of channels
      bus.out_ready0 = 1'b0;
      applyStimulus(1'b1, 16'h1234, 1'b0);
      step();
      applyStimulus(1'b1, 16'h5678, 1'b1);
      #1;
      checkOutput("ind_ready1", bus.in_ready, 1'b1);
      step();
      checkOutput("ind_valid1", bus.out_valid1, 1'b1);
      checkOutput("ind_data1", bus.demux_output1, 16'h5678);
      checkOutput("ind_valid0", bus.out_valid0, 1'b1);
      checkOutput("ind_data0", bus.demux_output0, 16'h1234);
      applyStimulus(1'b0, 16'h0000, 1'b0);
      step();
      checkOutput("ind_drain1", bus.out_valid1, 1'b0);
      checkOutput("ind_hold0", bus.demux_output0, 16'h1234);
      bus.out_ready0 = 1'b1;
      step();
      checkOutput("ind_drain0", bus.out_valid0, 1'b0);

      // Streaming alternating channels at full rate
      for (int i = 0; i < 8; i++) begin
         logic [15:0] word;
         logic        sel;
         word = 16'h0010 + 16'(i);
         sel  = (i % 2) == 1;
         applyStimulus(1'b1, word, sel);
         #1;
         checkOutput($sformatf("stream_ready_%0d", i), bus.in_ready, 1'b1);
         step();
         if (sel) begin
            checkOutput($sformatf("stream_v1_%0d", i), bus.out_valid1, 1'b1);
            checkOutput($sformatf("stream_d1_%0d", i), bus.demux_output1, word);
            checkOutput($sformatf("stream_other0_%0d", i), bus.out_valid0, 1'b0);
         end else begin
            checkOutput($sformatf("stream_v0_%0d", i), bus.out_valid0, 1'b1);
            checkOutput($sformatf("stream_d0_%0d", i), bus.demux_output0, word);
            checkOutput($sformatf("stream_other1_%0d", i), bus.out_valid1, 1'b0);
         end
      end
      applyStimulus(1'b0, 16'h0000, 1'b0);
      step();
      checkOutput("stream_end_v0", bus.out_valid0, 1'b0);
      checkOutput("stream_end_v1", bus.out_valid1, 1'b0);

`ifdef DEMUX_STATS_EN
      // Counters, reset mid-operation, and wrap
      rst = 1'b1;
      step();
      rst = 1'b0;
      checkOutput("stats_clr0", bus.count0, 16'h0000);
      checkOutput("stats_clr1", bus.count1, 16'h0000);
      bus.out_ready0 = 1'b0;
      bus.out_ready1 = 1'b1;
      applyStimulus(1'b1, 16'hC0DE, 1'b0);
      step();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 16'h0100 + 16'(i), 1'b1);
         step();
      end
      applyStimulus(1'b0, 16'h0000, 1'b0);
      step();
      checkOutput("stats_count1", bus.count1, 16'd3);
      checkOutput("stats_count0", bus.count0, 16'd0);
      checkOutput("stats_full0", bus.out_valid0, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      checkOutput("stats_rst_valid0", bus.out_valid0, 1'b0);
      checkOutput("stats_rst_count1", bus.count1, 16'd0);
      checkOutput("stats_rst_count0", bus.count0, 16'd0);

      bus.out_ready0 = 1'b1;
      applyStimulus(1'b1, 16'h0F0F, 1'b0);
      repeat (32'h10000) @(posedge clk);
      #1;
      checkOutput("stats_max0", bus.count0, 16'hFFFF);
      step();
      checkOutput("stats_wrap0", bus.count0, 16'h0000);
      applyStimulus(1'b0, 16'h0000, 1'b0);
      step();
`endif

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
